// File: rtl/osd_pkg.sv
// Shared constants and helpers for the on-screen-display overlay.
package osd_pkg;

  // Active-pixel coordinate width and the widened width used for region ends.
  localparam int COORD_W  = 12;
  localparam int REGION_W = 14;

  // Pixel replication factor is 1 << scale.
  typedef enum logic [1:0] {
    OSD_SCALE_1 = 2'd0,
    OSD_SCALE_2 = 2'd1,
    OSD_SCALE_4 = 2'd2,
    OSD_SCALE_8 = 2'd3
  } osd_scale_e;

  // Background handling for zero bits of the glyph bitmap.
  localparam logic OSD_MODE_TRANSP = 1'b0;
  localparam logic OSD_MODE_OPAQUE = 1'b1;

  // Default block parameters.
  localparam int OSD_DEF_DATA_WIDTH = 16;
  localparam int OSD_DEF_W          = 128;
  localparam int OSD_DEF_H          = 32;

  // Exclusive end of an overlay span; widened so origins near 4095 never wrap.
  function automatic logic [REGION_W-1:0] osd_region_end(
    input logic [COORD_W-1:0]  origin,
    input logic [REGION_W-1:0] span,
    input logic [1:0]          scale
  );
    return REGION_W'(origin) + (span << scale);
  endfunction

endpackage

// File: rtl/osd_pos_counter.sv
// Active-pixel x/y position tracker driven by data-enable and vertical sync.
module osd_pos_counter
  import osd_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               i_de,
  input  logic               i_vs,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  logic               de_prev_q, de_prev_d;
  logic               vs_prev_q, vs_prev_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // x counts active pixels in the line; y counts completed lines since vsync.
  always_comb begin
    de_prev_d = i_de;
    vs_prev_d = i_vs;
    x_d       = i_de ? x_q + COORD_W'(1) : '0;
    y_d       = y_q;
    if (i_vs && !vs_prev_q) begin
      y_d = '0;
    end else if (de_prev_q && !i_de) begin
      y_d = y_q + COORD_W'(1);
    end
  end

  // Counter state registers with synchronous reset (rst_n is active-high).
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/osd_overlay.sv
// Glyph-bitmap overlay on a video stream: double-buffered bitmap, frame-latched
// configuration and a two-stage pixel pipeline (region/lookup, then colour mux).
module osd_overlay
  import osd_pkg::*;
#(
  parameter int DATA_WIDTH = OSD_DEF_DATA_WIDTH,
  parameter int OSD_W      = OSD_DEF_W,
  parameter int OSD_H      = OSD_DEF_H,
  parameter int RW         = (OSD_H > 1) ? $clog2(OSD_H) : 1
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [COORD_W-1:0]    cfg_x,
  input  logic [COORD_W-1:0]    cfg_y,
  input  logic [1:0]            cfg_scale,
  input  logic [DATA_WIDTH-1:0] cfg_fg,
  input  logic [DATA_WIDTH-1:0] cfg_bg,
  input  logic                  cfg_mode,
  input  logic                  osd_en,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_row,
  input  logic [OSD_W-1:0]      wr_data,
  input  logic                  commit,
  output logic                  pending
);

  localparam int CW = (OSD_W > 1) ? $clog2(OSD_W) : 1;

  // Position of the pixel currently on the inputs.
  logic [COORD_W-1:0] pos_x, pos_y;

  osd_pos_counter u_pos (
    .pclk  (pclk),
    .rst_n (rst_n),
    .i_de  (i_de),
    .i_vs  (i_vs),
    .x     (pos_x),
    .y     (pos_y)
  );

  // Frame control.
  logic vs_prev_q, vs_prev_d;
  logic pending_q, pending_d;
  logic vs_rise, publish;

  // Frame-latched configuration.
  logic [COORD_W-1:0]    cfg_x_q, cfg_x_d, cfg_y_q, cfg_y_d;
  logic [1:0]            cfg_scale_q, cfg_scale_d;
  logic [DATA_WIDTH-1:0] cfg_fg_q, cfg_fg_d, cfg_bg_q, cfg_bg_d;
  logic                  cfg_mode_q, cfg_mode_d, osd_en_q, osd_en_d;

  // Stage 1: delayed video plus region flag and bitmap coordinates.
  logic                  s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_hit_q, s1_hit_d;
  logic [RW-1:0]         s1_row_q, s1_row_d;
  logic [CW-1:0]         s1_col_q, s1_col_d;

  // Stage 2: output registers.
  logic                  o_hs_q, o_hs_d, o_vs_q, o_vs_d, o_de_q, o_de_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

  // Pending (CPU-written) and active (displayed) bitmaps.
  logic [OSD_W-1:0] pend_q [OSD_H];
  logic [OSD_W-1:0] pend_d [OSD_H];
  logic [OSD_W-1:0] act_q  [OSD_H];
  logic [OSD_W-1:0] act_d  [OSD_H];

  // The copy reads pend_q, so a write landing in the publish cycle only
  // reaches the pending buffer and never the image being published.
  genvar gi;
  generate
    for (gi = 0; gi < OSD_H; gi++) begin : g_row
      assign pend_d[gi] = (wr_en && (wr_row == RW'(gi))) ? wr_data : pend_q[gi];
      assign act_d[gi]  = publish ? pend_q[gi] : act_q[gi];
    end
  endgenerate

  // Frame edge detection, publish handshake and configuration latch.
  always_comb begin
    vs_prev_d   = i_vs;
    vs_rise     = i_vs && !vs_prev_q;
    publish     = vs_rise && (pending_q || commit);
    pending_d   = pending_q;
    if (publish) begin
      pending_d = 1'b0;
    end else if (commit) begin
      pending_d = 1'b1;
    end
    cfg_x_d     = cfg_x_q;
    cfg_y_d     = cfg_y_q;
    cfg_scale_d = cfg_scale_q;
    cfg_fg_d    = cfg_fg_q;
    cfg_bg_d    = cfg_bg_q;
    cfg_mode_d  = cfg_mode_q;
    osd_en_d    = osd_en_q;
    if (vs_rise) begin
      cfg_x_d     = cfg_x;
      cfg_y_d     = cfg_y;
      cfg_scale_d = cfg_scale;
      cfg_fg_d    = cfg_fg;
      cfg_bg_d    = cfg_bg;
      cfg_mode_d  = cfg_mode;
      osd_en_d    = osd_en;
    end
  end

  // Stage 1: region test in widened arithmetic, then scaled bitmap coordinates.
  always_comb begin
    logic                  in_x, in_y;
    logic [COORD_W-1:0]    dx, dy;
    in_x = (pos_x >= cfg_x_q) &&
           (REGION_W'(pos_x) < osd_region_end(cfg_x_q, REGION_W'(OSD_W), cfg_scale_q));
    in_y = (pos_y >= cfg_y_q) &&
           (REGION_W'(pos_y) < osd_region_end(cfg_y_q, REGION_W'(OSD_H), cfg_scale_q));
    dx        = pos_x - cfg_x_q;
    dy        = pos_y - cfg_y_q;
    s1_hs_d   = i_hs;
    s1_vs_d   = i_vs;
    s1_de_d   = i_de;
    s1_data_d = i_data;
    s1_hit_d  = i_de && osd_en_q && in_x && in_y;
    s1_col_d  = CW'(dx >> cfg_scale_q);
    s1_row_d  = RW'(dy >> cfg_scale_q);
  end

  // Stage 2: bitmap lookup (MSB is the leftmost column) and colour selection.
  always_comb begin
    logic [CW-1:0] bit_idx;
    logic          glyph_bit;
    bit_idx   = CW'(OSD_W - 1) - s1_col_q;
    glyph_bit = act_q[s1_row_q][bit_idx];
    o_hs_d    = s1_hs_q;
    o_vs_d    = s1_vs_q;
    o_de_d    = s1_de_q;
    o_data_d  = s1_data_q;
    if (s1_hit_q) begin
      if (glyph_bit) begin
        o_data_d = cfg_fg_q;
      end else if (cfg_mode_q == OSD_MODE_OPAQUE) begin
        o_data_d = cfg_bg_q;
      end
    end
  end

  // All state registers; reset clears bitmaps, config, pipeline and any pending commit.
  always_ff @(posedge pclk) begin
    if (rst_n) begin
      vs_prev_q   <= 1'b0;
      pending_q   <= 1'b0;
      cfg_x_q     <= '0;
      cfg_y_q     <= '0;
      cfg_scale_q <= OSD_SCALE_1;
      cfg_fg_q    <= '0;
      cfg_bg_q    <= '0;
      cfg_mode_q  <= OSD_MODE_TRANSP;
      osd_en_q    <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_de_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_hit_q    <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      o_hs_q      <= 1'b0;
      o_vs_q      <= 1'b0;
      o_de_q      <= 1'b0;
      o_data_q    <= '0;
      for (int r = 0; r < OSD_H; r++) begin
        pend_q[r] <= '0;
        act_q[r]  <= '0;
      end
    end else begin
      vs_prev_q   <= vs_prev_d;
      pending_q   <= pending_d;
      cfg_x_q     <= cfg_x_d;
      cfg_y_q     <= cfg_y_d;
      cfg_scale_q <= cfg_scale_d;
      cfg_fg_q    <= cfg_fg_d;
      cfg_bg_q    <= cfg_bg_d;
      cfg_mode_q  <= cfg_mode_d;
      osd_en_q    <= osd_en_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_de_q     <= s1_de_d;
      s1_data_q   <= s1_data_d;
      s1_hit_q    <= s1_hit_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      o_hs_q      <= o_hs_d;
      o_vs_q      <= o_vs_d;
      o_de_q      <= o_de_d;
      o_data_q    <= o_data_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  assign o_hs    = o_hs_q;
  assign o_vs    = o_vs_q;
  assign o_de    = o_de_q;
  assign o_data  = o_data_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_osd_overlay.sv
// Directed bench for osd_overlay: short synthetic frames (only lines of interest
// are full width), a table of hand-computed pixel expectations, a two-deep
// history of driven syncs for the 2-cycle latency check, and hand sequences
// for commit timing and mid-frame reset.
module tb_osd_overlay;

  localparam int DW = 16;
  localparam int OW = 128;
  localparam int OH = 32;
  localparam int RWB = 5;
  localparam logic [DW-1:0] FG  = 16'hF800;
  localparam logic [DW-1:0] BG  = 16'h001F;

  logic           pclk = 1'b0;
  logic           rst_n;
  logic           i_hs, i_vs, i_de;
  logic [DW-1:0]  i_data;
  logic           o_hs, o_vs, o_de;
  logic [DW-1:0]  o_data;
  logic [11:0]    cfg_x, cfg_y;
  logic [1:0]     cfg_scale;
  logic [DW-1:0]  cfg_fg, cfg_bg;
  logic           cfg_mode, osd_en;
  logic           wr_en;
  logic [RWB-1:0] wr_row;
  logic [OW-1:0]  wr_data;
  logic           commit, pending;

  osd_overlay #(.DATA_WIDTH(DW), .OSD_W(OW), .OSD_H(OH)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
    .cfg_fg(cfg_fg), .cfg_bg(cfg_bg), .cfg_mode(cfg_mode), .osd_en(osd_en),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .commit(commit), .pending(pending)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            f;
    int            x;
    int            y;
    logic [DW-1:0] exp;
    int            hits;
  } vec_t;

  typedef struct {
    logic          hs, vs, de;
    logic          chk;
    logic [DW-1:0] exp;
    int            tx, ty;
  } rec_t;

  vec_t vecs[$];
  rec_t cur, h1, h2, zrec;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input int f, input int x, input int y, input logic [DW-1:0] e);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.exp = e; v.hits = 0;
    vecs.push_back(v);
  endtask

  function automatic logic [DW-1:0] pix(input int idx);
    logic [DW-1:0] v;
    v = 16'h5000 | DW'(idx & 32'hFFF);
    return v;
  endfunction

  function automatic bit is_wide(input int f, input int y);
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].f == f && vecs[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic find(input int f, input int x, input int y, output logic hit, output logic [DW-1:0] e);
    hit = 1'b0;
    e   = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].f == f && vecs[i].x == x && vecs[i].y == y) begin
        hit = 1'b1;
        e   = vecs[i].exp;
        vecs[i].hits++;
      end
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de, input logic [DW-1:0] d,
                       input logic chk, input logic [DW-1:0] e, input int tx, input int ty);
    i_hs = hs; i_vs = vs; i_de = de; i_data = d;
    cur.hs = hs; cur.vs = vs; cur.de = de;
    cur.chk = chk; cur.exp = e; cur.tx = tx; cur.ty = ty;
  endtask

  // Advance one clock, then compare outputs with what was driven two cycles earlier.
  task automatic tick();
    @(posedge pclk);
    #1;
    if (rst_n) begin
      h1 = zrec;
      h2 = zrec;
    end else begin
      h2 = h1;
      h1 = cur;
    end
    n_checks++;
    if ({o_hs, o_vs, o_de} !== {h2.hs, h2.vs, h2.de}) begin
      n_fail++;
      $display("FAIL sync_lag t=%0t: got hs/vs/de=%b%b%b required %b%b%b",
               $time, o_hs, o_vs, o_de, h2.hs, h2.vs, h2.de);
    end
    if (h2.chk) begin
      n_checks++;
      if (o_data !== h2.exp) begin
        n_fail++;
        $display("FAIL pixel(%0d,%0d) t=%0t: got o_data=%h required %h",
                 h2.tx, h2.ty, $time, o_data, h2.exp);
      end
    end
  endtask

  task automatic idle(input logic hs, input logic vs);
    drive(hs, vs, 1'b0, '0, 1'b1, '0, -1, -1);
    tick();
  endtask

  task automatic chk_pend(input string nm, input logic e);
    n_checks++;
    if (pending !== e) begin
      n_fail++;
      $display("FAIL pending_%s: got %b required %b", nm, pending, e);
    end
  endtask

  // One synthetic frame. Lines listed in the table are w pixels wide, the rest 1.
  // mid_act 1: write row 0 all-ones and commit; 2: disturb cfg inputs mid-frame.
  // vs_act 1: write row 0 = 0 in the vs-rise cycle; 2: commit in the vs-rise cycle.
  task automatic run_frame(input int f, input int nl, input int w, input int mid_line,
                           input int mid_act, input int vs_act, input int pend_pre,
                           input int pend_post);
    logic          hit;
    logic [DW-1:0] e;
    int            wl;
    if (pend_pre >= 0) chk_pend("before_vs", pend_pre != 0);
    if (vs_act == 1) begin wr_en = 1'b1; wr_row = '0; wr_data = '0; end
    if (vs_act == 2) commit = 1'b1;
    idle(1'b0, 1'b1);
    wr_en  = 1'b0;
    commit = 1'b0;
    if (pend_post >= 0) chk_pend("after_vs", pend_post != 0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int y = 0; y < nl; y++) begin
      if (y == mid_line) begin
        if (mid_act == 1) begin
          wr_en = 1'b1; wr_row = '0; wr_data = '1;
          idle(1'b0, 1'b0);
          wr_en = 1'b0; commit = 1'b1;
          idle(1'b0, 1'b0);
          commit = 1'b0;
          idle(1'b0, 1'b0);
          chk_pend("mid_commit", 1'b1);
        end else if (mid_act == 2) begin
          cfg_fg = 16'h07E0; cfg_x = 12'd0; osd_en = 1'b0;
        end
      end
      idle(1'b1, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      wl = is_wide(f, y) ? w : 1;
      for (int x = 0; x < wl; x++) begin
        find(f, x, y, hit, e);
        drive(1'b0, 1'b0, 1'b1, pix(x), hit, e, x, y);
        tick();
      end
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
    end
  endtask

  initial begin
    zrec = '{hs: 1'b0, vs: 1'b0, de: 1'b0, chk: 1'b1, exp: '0, tx: -1, ty: -1};
    cur  = zrec;

    // Frame 0: 1x scale, transparent; row 0 has only its outer bits set.
    add(0, 100, 50, FG);     add(0, 227, 50, FG);     add(0, 99, 50, 16'h5063);
    add(0, 228, 50, 16'h50E4); add(0, 101, 50, 16'h5065); add(0, 226, 50, 16'h50E2);
    add(0, 100, 81, 16'h5064); add(0, 100, 82, 16'h5064);
    // Frame 1: 4x scale, transparent.
    add(1, 100, 50, FG);     add(1, 103, 53, FG);     add(1, 104, 50, 16'h5068);
    add(1, 100, 54, 16'h5064); add(1, 611, 53, FG);   add(1, 608, 50, FG);
    add(1, 612, 50, 16'h5264);
    // Frame 2: 4x scale, opaque background.
    add(2, 104, 50, BG);     add(2, 100, 177, BG);    add(2, 100, 178, 16'h5064);
    add(2, 611, 177, BG);    add(2, 612, 177, 16'h5264); add(2, 99, 100, 16'h5063);
    add(2, 100, 50, FG);
    // Frame 3: commit mid-frame, old image still shown.
    add(3, 100, 50, FG);     add(3, 101, 50, 16'h5065);
    // Frame 4: new all-ones row 0 shown.
    add(4, 101, 50, FG);     add(4, 150, 50, FG);     add(4, 227, 50, FG);
    add(4, 228, 50, 16'h50E4);
    // Frame 5: commit at vs publishes the row written in the previous copy cycle (zeros).
    add(5, 100, 50, 16'h5064); add(5, 227, 50, 16'h50E3);
    // Frame 6: origin near the coordinate limit, opaque; clipped at 4095.
    add(6, 3999, 0, 16'h5F9F); add(6, 4000, 0, BG);   add(6, 4095, 0, BG);
    add(6, 4096, 0, 16'h5000); add(6, 4097, 0, 16'h5001);
    // Frame 7: overlay disabled.
    add(7, 101, 50, 16'h5065); add(7, 100, 50, 16'h5064);

    rst_n = 1'b1;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_data = '0;
    cfg_x = 12'd100; cfg_y = 12'd50; cfg_scale = 2'd0;
    cfg_fg = FG; cfg_bg = BG; cfg_mode = 1'b0; osd_en = 1'b1;
    wr_en = 1'b0; wr_row = '0; wr_data = '0; commit = 1'b0;

    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk_pend("reset", 1'b0);
    rst_n = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    wr_en = 1'b1; wr_row = '0; wr_data = {1'b1, 126'd0, 1'b1};
    idle(1'b0, 1'b0);
    wr_en = 1'b0; commit = 1'b1;
    idle(1'b0, 1'b0);
    commit = 1'b0;
    chk_pend("after_commit", 1'b1);

    run_frame(0, 83, 300, 10, 2, 0, 1, 0);
    cfg_fg = FG; cfg_x = 12'd100; osd_en = 1'b1; cfg_scale = 2'd2;
    run_frame(1, 179, 620, -1, 0, 0, -1, -1);
    cfg_mode = 1'b1;
    run_frame(2, 179, 620, -1, 0, 0, -1, -1);
    cfg_scale = 2'd0; cfg_mode = 1'b0;
    run_frame(3, 51, 300, 40, 1, 0, 0, 0);
    run_frame(4, 51, 300, -1, 0, 1, 1, 0);
    run_frame(5, 51, 300, -1, 0, 2, 0, 0);
    cfg_x = 12'd4000; cfg_y = 12'd0; cfg_mode = 1'b1;
    run_frame(6, 1, 4100, -1, 0, 0, -1, -1);
    cfg_x = 12'd100; cfg_y = 12'd50; osd_en = 1'b0;
    run_frame(7, 51, 300, -1, 0, 0, -1, -1);

    // Mid-frame reset: overlay active at the origin, commit pending, then reset.
    cfg_x = 12'd0; cfg_y = 12'd0; cfg_scale = 2'd0; cfg_mode = 1'b1; osd_en = 1'b1;
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int x = 0; x < 6; x++) begin
      drive(1'b0, 1'b0, 1'b1, pix(x), 1'b1, BG, x, 0);
      tick();
    end
    commit = 1'b1;
    drive(1'b0, 1'b0, 1'b1, pix(6), 1'b1, BG, 6, 0);
    tick();
    commit = 1'b0;
    chk_pend("before_reset", 1'b1);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, pix(7), 1'b1, BG, 7, 0);
    tick();
    chk_pend("reset_clears", 1'b0);
    n_checks++;
    if ({o_hs, o_vs, o_de, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hs/vs/de=%b%b%b data=%h required all zero",
               o_hs, o_vs, o_de, o_data);
    end
    rst_n = 1'b0;
    for (int x = 0; x < 6; x++) begin
      drive(1'b0, 1'b0, 1'b1, pix(x), 1'b1, pix(x), x, 0);
      tick();
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    chk_pend("discarded", 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    for (int x = 0; x < 6; x++) begin
      drive(1'b0, 1'b0, 1'b1, pix(x), 1'b1, BG, x, 0);
      tick();
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Every table entry must have been visited by the stimulus.
    for (int i = 0; i < vecs.size(); i++) begin
      n_checks++;
      if (vecs[i].hits != 1) begin
        n_fail++;
        $display("FAIL vec_reached f%0d (%0d,%0d): got %0d visits required 1",
                 vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].hits);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_overlay.md
OSD_OVERLAY -- requirements
Module: osd_overlay

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel word width.
REQ-002 SHALL have parameter OSD_W, default 128, glyph bitmap width in source pixels.
REQ-003 SHALL have parameter OSD_H, default 32, glyph bitmap height in rows; RW = clog2(OSD_H).
REQ-004 SHALL have port pclk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-high (asserted when 1).
REQ-006 SHALL have ports i_hs, i_vs, i_de  in  1 each  input video sync/enable.
REQ-007 SHALL have port i_data  in  DATA_WIDTH  input pixel.
REQ-008 SHALL have ports o_hs, o_vs, o_de  out  1 each  delayed sync/enable.
REQ-009 SHALL have port o_data  out  DATA_WIDTH  overlaid pixel.
REQ-010 SHALL have ports cfg_x, cfg_y  in  12 each  overlay origin in active-pixel coordinates.
REQ-011 SHALL have port cfg_scale  in  2  replication factor 1<<cfg_scale (1,2,4,8).
REQ-012 SHALL have ports cfg_fg, cfg_bg  in  DATA_WIDTH each  foreground/background colour.
REQ-013 SHALL have port cfg_mode  in  1  0 = transparent background, 1 = opaque cfg_bg.
REQ-014 SHALL have port osd_en  in  1  overlay enable.
REQ-015 SHALL have ports wr_en in 1, wr_row in RW, wr_data in OSD_W  bitmap row write.
REQ-016 SHALL have port commit  in  1  single-cycle request to publish the pending bitmap.
REQ-017 SHALL have port pending  out  1  high from commit until the publish completes.

Function
REQ-018 x counter SHALL increment per i_de=1 cycle and clear on the cycle after i_de falls; y SHALL increment on each i_de falling edge and clear on i_vs rising edge.
REQ-019 wr_en SHALL write wr_data into pending-buffer row wr_row; wr_row >= OSD_H SHALL be ignored.
REQ-020 On the first i_vs rising edge with pending=1 the active bitmap SHALL be copied from the pending buffer and pending SHALL clear the next cycle.
REQ-021 A wr_en in the copy cycle SHALL update only the pending buffer, not the copied image.
REQ-022 commit coincident with the i_vs rising edge SHALL publish in that same cycle.
REQ-023 cfg_x, cfg_y, cfg_scale, cfg_fg, cfg_bg, cfg_mode, osd_en SHALL be sampled only on i_vs rising edge (frame-stable).
REQ-024 Region SHALL be cfg_x <= x < cfg_x+(OSD_W<<s) and cfg_y <= y < cfg_y+(OSD_H<<s), computed in 14 bits with no wrap; parts beyond 4095 are clipped.
REQ-025 In region: col=(x-cfg_x)>>s, row=(y-cfg_y)>>s; bit = active[row][OSD_W-1-col] (MSB leftmost).
REQ-026 o_data SHALL be cfg_fg if bit=1; cfg_bg if bit=0 and cfg_mode=1; else i_data. Outside region, i_de=0, or osd_en=0: i_data.
REQ-027 o_hs, o_vs, o_de, o_data SHALL all lag inputs by exactly 2 pclk cycles.

Reset
REQ-028 Under rst_n=1: o_* = 0, pending = 0, counters = 0, both bitmaps all-zero, latched config = 0 (osd disabled).
REQ-029 Reset mid-frame SHALL discard a pending commit; after release, overlay stays off until the next i_vs rising edge.

Structure
REQ-030 Shared package osd_pkg SHALL hold the coordinate width (12), scale encoding, mode constants (OSD_MODE_TRANSP=0, OSD_MODE_OPAQUE=1) and default parameters.
REQ-031 Coordinate counters SHALL be a sub-module osd_pos_counter (pclk, rst_n, i_de, i_vs -> x, y); bitmaps, pipeline and mux remain in osd_overlay.

Verification
REQ-032 1280x720 frame, cfg_x=100, cfg_y=50, scale=0, row 0 = 128'h8000...0001, mode 0 -> o_data=cfg_fg at (100,50) and (227,50); i_data at (99,50),(228,50),(100,82).
REQ-033 scale=2, same bitmap -> pixels (100..103, 50..53) = cfg_fg; region ends x=611, y=177.
REQ-034 mode 1, cfg_bg=16'h001F -> zero bits in region output 16'h001F; outside, i_data unchanged.
REQ-035 Write new bitmap, commit mid-frame -> current frame shows old image, pending=1; next frame shows new, pending=0 one cycle after vs rise; wr_en in copy cycle absent from the new image.
REQ-036 cfg_x=4000 -> clipped at x=4095, no wrap to x=0; reset asserted mid-frame -> all outputs 0 next cycle, pending cleared.
REQ-037 Every case: o_hs/o_vs/o_de equal inputs delayed exactly 2 cycles.
